// File: rtl/cv32e41p_irq_pend_arbiter.sv
// cv32e41p_irq_pend_arbiter
//
// Purpose: keeps the pending state of the external interrupt lines and picks
// which one goes to the controller. Each implemented line is either
// level-sensitive or rising-edge-sensitive. Edge events are latched until they
// are acknowledged or cleared by software. The highest-priority enabled pending
// line is handed to the controller through a req/ack handshake, and its id is
// held stable for as long as the request is up.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   irq_i            raw interrupt lines
//   edge_cfg_i       per-line mode, 1 = rising edge, 0 = level
//   mie_i, m_ie_i    per-line enables and global machine enable
//   sw_clr_valid_i   software clear strobe for edge line sw_clr_id_i
//   sw_clr_id_i      line to clear
//   mip_o            pending view for the MIP CSR
//   irq_req_o        request to the controller
//   irq_id_o         id of the requested line
//   irq_ack_i        controller accepts the request
//   irq_ack_id_o     one-cycle pulse in the cycle after an accepted ack
//   irq_wu_o         combinational wake-up from the raw lines
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request; latch the arbitration winner when anything qualifies
// REQ   | request up with a frozen id; wait for ack or loss of qualification
// ACK   | one dead cycle that pulses irq_ack_id_o before re-arbitrating

module cv32e41p_irq_pend_arbiter #(
    parameter logic [31:0] IRQ_MASK = 32'hFFFF_0888
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_i,
    input  logic [31:0] edge_cfg_i,
    input  logic [31:0] mie_i,
    input  logic        m_ie_i,
    input  logic        sw_clr_valid_i,
    input  logic [4:0]  sw_clr_id_i,
    output logic [31:0] mip_o,
    output logic        irq_req_o,
    output logic [4:0]  irq_id_o,
    input  logic        irq_ack_i,
    output logic        irq_ack_id_o,
    output logic        irq_wu_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] irq_q;
    logic [31:0] irq_d_q;
    logic [31:0] edge_pend_q;
    logic [4:0]  id_q;
    logic        req_q;
    logic        ack_id_q;

    logic [31:0] rise;
    logic [31:0] clr_vec;
    logic [31:0] qual;
    logic [4:0]  sel_id;
    logic        ack_acc;

    // Fixed arbitration order: position 0 has the highest priority.
    function automatic logic [4:0] prio_id(input int unsigned k);
        logic [4:0] id;
        if (k < 16) begin
            id = 5'(31 - k);
        end else begin
            case (k)
                16:      id = 5'd11;
                17:      id = 5'd3;
                18:      id = 5'd7;
                19:      id = 5'd15;
                20:      id = 5'd14;
                21:      id = 5'd13;
                22:      id = 5'd12;
                23:      id = 5'd10;
                24:      id = 5'd2;
                25:      id = 5'd6;
                26:      id = 5'd9;
                27:      id = 5'd1;
                28:      id = 5'd5;
                29:      id = 5'd8;
                30:      id = 5'd0;
                default: id = 5'd4;
            endcase
        end
        return id;
    endfunction

    assign rise    = irq_q & ~irq_d_q & edge_cfg_i;
    assign mip_o   = (irq_q & ~edge_cfg_i) | (edge_pend_q & edge_cfg_i);
    assign qual    = mip_o & mie_i & {32{m_ie_i}};
    assign ack_acc = (state_q == S_REQ) && irq_ack_i;

    always_comb begin
        clr_vec = '0;
        if (sw_clr_valid_i) clr_vec[sw_clr_id_i] = 1'b1;
        if (ack_acc)        clr_vec[id_q]        = 1'b1;
    end

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        sel_id = '0;
        for (int k = 31; k >= 0; k--) begin
            if (qual[prio_id(k)]) sel_id = prio_id(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q       <= '0;
            irq_d_q     <= '0;
            edge_pend_q <= '0;
            state_q     <= S_IDLE;
            id_q        <= '0;
            req_q       <= 1'b0;
            ack_id_q    <= 1'b0;
        end else begin
            irq_q       <= irq_i & IRQ_MASK;
            irq_d_q     <= irq_q;
            // A new rise wins over a clear of the same bit.
            edge_pend_q <= (edge_pend_q & ~clr_vec) | rise;
            case (state_q)
                S_IDLE: begin
                    req_q    <= 1'b0;
                    ack_id_q <= 1'b0;
                    if (|qual) begin
                        id_q    <= sel_id;
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Ack takes precedence over a simultaneous loss of qualification.
                    if (irq_ack_i) begin
                        state_q  <= S_ACK;
                        req_q    <= 1'b0;
                        ack_id_q <= 1'b1;
                    end else if (!qual[id_q]) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    req_q    <= 1'b0;
                    ack_id_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o    = req_q;
    assign irq_id_o     = id_q;
    assign irq_ack_id_o = ack_id_q;
    assign irq_wu_o     = |(irq_i & mie_i & IRQ_MASK);

endmodule

// File: tb/tb_cv32e41p_irq_pend_arbiter.sv
// Bench for cv32e41p_irq_pend_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model.

module tb_cv32e41p_irq_pend_arbiter;

    localparam logic [31:0] MASK = 32'hFFFF_0888;
    localparam int PRIO [32] = '{31, 30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20, 19, 18, 17, 16,
                                 11, 3, 7, 15, 14, 13, 12, 10, 2, 6, 9, 1, 5, 8, 0, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] irq_i = '0;
    logic [31:0] edge_cfg_i = '0;
    logic [31:0] mie_i = '0;
    logic        m_ie_i = 1'b0;
    logic        sw_clr_valid_i = 1'b0;
    logic [4:0]  sw_clr_id_i = '0;
    logic [31:0] mip_o;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i = 1'b0;
    logic        irq_ack_id_o;
    logic        irq_wu_o;

    int passed = 0;
    int total  = 0;

    // Model: sampled lines, one-cycle-older samples, latched edges, handshake phase.
    bit [31:0] m_now, m_old, m_edge;
    int        m_phase;   // 0 none, 1 requesting, 2 acknowledged
    int        m_id;

    cv32e41p_irq_pend_arbiter dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .edge_cfg_i(edge_cfg_i), .mie_i(mie_i),
        .m_ie_i(m_ie_i), .sw_clr_valid_i(sw_clr_valid_i), .sw_clr_id_i(sw_clr_id_i),
        .mip_o(mip_o), .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
        .irq_ack_id_o(irq_ack_id_o), .irq_wu_o(irq_wu_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit [31:0] m_pending();
        bit [31:0] p;
        for (int b = 0; b < 32; b++)
            p[b] = edge_cfg_i[b] ? m_edge[b] : m_now[b];
        return p;
    endfunction

    task automatic model_tick();
        bit [31:0] qual, nxt;
        int        win;
        bit        accepted;
        if (rst) begin
            m_now = '0; m_old = '0; m_edge = '0; m_phase = 0; m_id = 0;
            return;
        end
        qual = m_ie_i ? (m_pending() & mie_i) : '0;
        win = -1;
        foreach (PRIO[i]) if (win < 0 && qual[PRIO[i]]) win = PRIO[i];
        accepted = (m_phase == 1) && irq_ack_i;
        for (int b = 0; b < 32; b++) begin
            if (edge_cfg_i[b] && m_now[b] && !m_old[b])
                nxt[b] = 1'b1;
            else if ((sw_clr_valid_i && sw_clr_id_i == b) || (accepted && m_id == b))
                nxt[b] = 1'b0;
            else
                nxt[b] = m_edge[b];
        end
        m_edge = nxt;
        if (m_phase == 0) begin
            if (win >= 0) begin m_phase = 1; m_id = win; end
        end else if (m_phase == 1) begin
            if (irq_ack_i) m_phase = 2;
            else if (!qual[m_id]) m_phase = 0;
        end else begin
            m_phase = 0;
        end
        m_old = m_now;
        m_now = irq_i & MASK;
    endtask

    // One clock: check wake-up on the settled inputs, advance, compare outputs.
    task automatic step();
        #1;
        check("wu", {31'b0, irq_wu_o}, {31'b0, |(irq_i & mie_i & MASK)});
        @(posedge clk);
        model_tick();
        #1;
        check("mip", mip_o, m_pending());
        check("req", {31'b0, irq_req_o}, {31'b0, m_phase == 1});
        check("id", {27'b0, irq_id_o}, m_id);
        check("ack_id", {31'b0, irq_ack_id_o}, {31'b0, m_phase == 2});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clean_reset();
        rst = 1'b1; irq_i = '0; edge_cfg_i = '0; mie_i = '0; m_ie_i = 1'b0;
        irq_ack_i = 1'b0; sw_clr_valid_i = 1'b0; sw_clr_id_i = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with every line high.
        rst = 1'b1; irq_i = 32'hFFFF_FFFF;
        step();
        check("rst_mip", mip_o, 32'h0);
        check("rst_req", {31'b0, irq_req_o}, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_mip", mip_o, 32'hFFFF_0888);

        // Level line 11 with re-request after ack.
        clean_reset();
        mie_i = 32'h1 << 11; m_ie_i = 1'b1; irq_i[11] = 1'b1;
        steps(2);
        check("lvl_req", {31'b0, irq_req_o}, 32'h1);
        check("lvl_id", {27'b0, irq_id_o}, 32'd11);
        step();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("lvl_ackid", {31'b0, irq_ack_id_o}, 32'h1);
        steps(2);
        check("lvl_rereq", {31'b0, irq_req_o}, 32'h1);

        // Edge line 20, single-cycle pulse.
        clean_reset();
        edge_cfg_i[20] = 1'b1; mie_i = 32'h1 << 20; m_ie_i = 1'b1; irq_i[20] = 1'b1;
        step();
        irq_i[20] = 1'b0;
        step();
        check("edge_mip", mip_o[20], 32'h1);
        step();
        check("edge_req", {27'b0, irq_id_o, irq_req_o}, {26'b0, 5'd20, 1'b1});
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("edge_clr", mip_o[20], 32'h0);
        steps(4);
        check("edge_norereq", {31'b0, irq_req_o}, 32'h0);

        // Priority and no pre-emption.
        clean_reset();
        mie_i = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 16); m_ie_i = 1'b1;
        irq_i[3] = 1'b1; irq_i[7] = 1'b1;
        steps(2);
        check("prio_id", {27'b0, irq_id_o}, 32'd3);
        irq_i[16] = 1'b1;
        steps(3);
        check("nopreempt", {27'b0, irq_id_o, irq_req_o}, {26'b0, 5'd3, 1'b1});
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        steps(2);
        check("next_id", {27'b0, irq_id_o, irq_req_o}, {26'b0, 5'd16, 1'b1});

        // Withdraw on level drop.
        clean_reset();
        mie_i = 32'h1 << 7; m_ie_i = 1'b1; irq_i[7] = 1'b1;
        steps(3);
        irq_i[7] = 1'b0;
        steps(2);
        check("withdraw", {31'b0, irq_req_o}, 32'h0);

        // Withdraw on software clear of edge line 25.
        clean_reset();
        edge_cfg_i[25] = 1'b1; mie_i = 32'h1 << 25; m_ie_i = 1'b1; irq_i[25] = 1'b1;
        step();
        irq_i[25] = 1'b0;
        steps(3);
        sw_clr_valid_i = 1'b1; sw_clr_id_i = 5'd25;
        step();
        sw_clr_valid_i = 1'b0;
        check("swclr_mip", mip_o[25], 32'h0);
        step();
        check("swclr_wd", {31'b0, irq_req_o}, 32'h0);

        // Set beats clear on edge line 18.
        clean_reset();
        edge_cfg_i[18] = 1'b1; irq_i[18] = 1'b1;
        step();
        irq_i[18] = 1'b0;
        steps(3);
        irq_i[18] = 1'b1;
        step();
        sw_clr_valid_i = 1'b1; sw_clr_id_i = 5'd18; irq_i[18] = 1'b0;
        step();
        sw_clr_valid_i = 1'b0;
        check("set_wins", mip_o[18], 32'h1);

        // Masked line 13.
        clean_reset();
        mie_i = 32'hFFFF_FFFF; m_ie_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            irq_i[13] = ~irq_i[13];
            step();
            check("mask_mip", mip_o[13], 32'h0);
            check("mask_req", {31'b0, irq_req_o}, 32'h0);
        end

        // Random traffic.
        clean_reset();
        edge_cfg_i = $urandom();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) irq_i = $urandom() & $urandom();
            if ($urandom_range(0, 99) == 0) edge_cfg_i = $urandom();
            if ($urandom_range(0, 15) == 0) mie_i = $urandom() | $urandom();
            m_ie_i = ($urandom_range(0, 7) != 0);
            irq_ack_i = ($urandom_range(0, 2) == 0);
            sw_clr_valid_i = ($urandom_range(0, 5) == 0);
            sw_clr_id_i = 5'($urandom());
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
